uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single `UARTTransmitter` instance among `NUM_REQ` byte-stream requesters, such as the board display engine, the welcome-message ROM and a command echo/status source. Arbitration is packet-atomic: once a requester is granted, it keeps the transmitter until it sends a byte flagged `last`. A stall timeout forcibly releases the transmitter if the owning requester stops supplying bytes mid-packet. The block sits between the requesters and the transmitter's `valid`/`in`/`ready` pins.

---
 rtl/uart_tx_arbiter.sv | 90 +++++++++
 tb/tb_uart_tx_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-atomic round-robin sharing of one UART transmitter among NUM_REQ byte streams
module uart_tx_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 abort,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (STALL_TIMEOUT < 1) ? 1 : $clog2(STALL_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
  state_t state;
  logic [IW-1:0] owner, rr_last, sel, idx;
  logic [7:0] byte_reg;
  logic last_reg, xfer, timeout;
  logic [CW-1:0] stall_cnt, stall_nxt;
  assign tx_data = byte_reg;
  assign xfer = state == LOAD && req_valid[owner] && tx_ready;
  assign req_ready = xfer ? NUM_REQ'(1) << owner : '0;
  assign stall_nxt = &stall_cnt ? stall_cnt : stall_cnt + 1'b1;
  assign timeout = STALL_TIMEOUT != 0 && stall_nxt == CW'(STALL_TIMEOUT);
  // scan backwards so the requester nearest after rr_last is assigned last and wins
  always_comb begin
    sel = '0;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(rr_last) + k) % NUM_REQ);
      if (req_valid[idx]) sel = idx;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      rr_last   <= IW'(NUM_REQ - 1);
      byte_reg  <= '0;
      last_reg  <= 1'b0;
      stall_cnt <= '0;
      grant     <= '0;
      abort     <= 1'b0;
      tx_valid  <= 1'b0;
    end else begin
      abort <= 1'b0;
      case (state)
        IDLE: if (|req_valid) begin
          owner     <= sel;
          grant     <= NUM_REQ'(1) << sel;
          stall_cnt <= '0;
          state     <= LOAD;
        end
        LOAD: if (xfer) begin
          byte_reg  <= req_data[8*owner +: 8];
          last_reg  <= req_last[owner];
          tx_valid  <= 1'b1;
          stall_cnt <= '0;
          state     <= SEND;
        end else if (!req_valid[owner]) begin
          stall_cnt <= stall_nxt;
          if (timeout) begin
            abort   <= 1'b1;
            rr_last <= owner;
            grant   <= '0;
            state   <= IDLE;
          end
        end
        // the transmitter dropping ready is the only evidence it has latched the byte
        SEND: if (!tx_ready) begin
          tx_valid <= 1'b0;
          if (last_reg) begin
            rr_last <= owner;
            grant   <= '0;
            state   <= IDLE;
          end else begin
            state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized scoreboard bench with a packet-level round-robin model and a 4-cycle transmitter model
module tb_uart_tx_arbiter;
  localparam int N = 3;
  localparam int TMO = 16;
  localparam int BUSY = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_last = '0, req_ready, grant;
  logic [8*N-1:0] req_data = '0;
  logic abort, tx_valid, tx_ready = 1'b1;
  logic [7:0] tx_data;
  int tests = 0, fails = 0, cyc = 0, busy = 0, model_rr = N - 1;
  int rdy_cnt [N], mid [N], gap [N];
  bit drop_first [N];
  bit hold = 1'b0, bubbles = 1'b0;
  int abort_cnt = 0, abort_cyc = -1, latch_cyc = -1, stall_max = 0;
  logic [N-1:0] prev_grant = '0;
  logic [8:0] pq [N][$];
  logic [10:0] exp_q [$];
  int grant_log [$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .STALL_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant), .abort(abort), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic add(input int i, input logic [7:0] d, input bit l);
    pq[i].push_back({l, d});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #3;
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (pq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic flush();
    for (int i = 0; i < N; i++) begin
      pq[i].delete();
      mid[i] = 0;
      gap[i] = 0;
      rdy_cnt[i] = 0;
    end
    exp_q.delete();
    grant_log.delete();
    busy = 0;
    prev_grant = '0;
  endtask

  // whole packets are served in turn, the next owner being the first pending requester after the previous one
  task automatic run_model();
    logic [8:0] mq [N][$];
    logic [8:0] b;
    int sel;
    for (int i = 0; i < N; i++) mq[i] = pq[i];
    forever begin
      sel = -1;
      for (int k = 1; k <= N && sel < 0; k++) if (mq[(model_rr + k) % N].size() > 0) sel = (model_rr + k) % N;
      if (sel < 0) break;
      do begin
        b = mq[sel].pop_front();
        exp_q.push_back({2'(sel), b});
      end while (!b[8]);
      model_rr = sel;
    end
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || grant != 0 || pending()) && n < 3000) begin
      step(1);
      n++;
    end
    tests++;
    if (n >= 3000) begin
      fails++;
      $display("FAIL %s_timeout: %0d bytes outstanding, required 0", nm, exp_q.size());
    end
  endtask

  // requesters, transmitter model and scoreboard monitor
  initial begin
    bit v;
    logic [8:0] b;
    logic [10:0] e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        v = pq[i].size() > 0;
        if (v && bubbles && mid[i] > 0 && gap[i] < 3 && $urandom_range(0, 3) == 0) begin
          v = 1'b0;
          gap[i]++;
        end else begin
          gap[i] = 0;
        end
        req_valid[i] = v;
        if (pq[i].size() > 0) begin
          req_data[8*i +: 8] = pq[i][0][7:0];
          req_last[i] = pq[i][0][8];
        end
      end
      tx_ready = !hold && busy == 0;
      #1;
      if (rst_n) begin
        for (int i = 0; i < N; i++) if (req_ready[i]) begin
          rdy_cnt[i]++;
          if (pq[i].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL ready_without_data req%0d: ready 1, required 0", i);
          end else begin
            b = pq[i].pop_front();
            mid[i] = b[8] ? 0 : mid[i] + 1;
            if (drop_first[i]) begin
              pq[i].delete();
              mid[i] = 0;
            end
          end
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL tx_unexpected: byte %0h, required none", tx_data);
          end else begin
            e = exp_q.pop_front();
            check("tx_data", tx_data, e[7:0]);
            check("grant_at_tx", grant, 32'(1) << e[10:9]);
          end
          busy = BUSY;
          latch_cyc = cyc;
        end else if (busy > 0) begin
          busy--;
        end
        if (abort) begin
          abort_cnt++;
          abort_cyc = cyc;
        end
        if (int'(dut.stall_cnt) > stall_max) stall_max = int'(dut.stall_cnt);
        if (grant != 0 && prev_grant == 0) for (int i = 0; i < N; i++) if (grant[i]) grant_log.push_back(i);
        prev_grant = grant;
      end
      cyc++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] x;
    int n;
    step(3);
    check("rst_grant", grant, 0);
    check("rst_abort", abort, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_stall_cnt", dut.stall_cnt, 0);
    rst_n = 1'b1;
    step(2);
    add(0, 8'h1B, 0); add(0, 8'h5B, 0); add(0, 8'h48, 1);
    run_model();
    wait_done("single");
    check("single_ready_pulses", rdy_cnt[0], 3);
    check("single_grants", grant_log.size(), 1);
    rst_n = 1'b0;
    #1 flush();
    step(1);
    rst_n = 1'b1;
    model_rr = N - 1;
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) add(i, 8'h41 + 8'(i), 1);
    run_model();
    wait_done("fair");
    check("fair_grants", grant_log.size(), 6);
    for (int k = 0; k < grant_log.size(); k++) check("fair_order", grant_log[k], k % 3);
    grant_log.delete();
    rdy_cnt[1] = 0;
    for (int k = 0; k < 8; k++) add(1, 8'($urandom), k == 7);
    run_model();
    n = 0;
    while (rdy_cnt[1] < 2 && n < 200) begin step(1); n++; end
    check("atomic_two_bytes", rdy_cnt[1] >= 2, 1);
    x = 8'($urandom);
    add(0, x, 1);
    exp_q.push_back({2'd0, 1'b1, x});
    model_rr = 0;
    wait_done("atomic");
    check("atomic_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) check("atomic_second_owner", grant_log[1], 0);
    abort_cnt = 0;
    drop_first[2] = 1'b1;
    x = 8'($urandom);
    add(2, x, 0); add(2, 8'h5A, 1);
    exp_q.push_back({2'd2, 1'b0, x});
    n = 0;
    while (abort_cnt == 0 && n < 200) begin step(1); n++; end
    step(5);
    check("stall_abort_count", abort_cnt, 1);
    check("stall_abort_cycle", abort_cyc, latch_cyc + 2 + TMO);
    check("stall_grant_cleared", grant, 0);
    check("stall_byte_sent", exp_q.size(), 0);
    drop_first[2] = 1'b0;
    model_rr = 2;
    grant_log.delete();
    for (int i = 0; i < N; i++) add(i, 8'($urandom), 1);
    run_model();
    wait_done("after_abort");
    check("after_abort_first", grant_log.size() > 0 ? grant_log[0] : -1, 0);
    hold = 1'b1;
    rdy_cnt[1] = 0;
    abort_cnt = 0;
    stall_max = 0;
    add(1, 8'($urandom), 0); add(1, 8'($urandom), 1);
    run_model();
    step(50);
    check("bp_ready_pulses", rdy_cnt[1], 0);
    check("bp_abort", abort_cnt, 0);
    check("bp_stall_cnt", stall_max, 0);
    check("bp_grant", grant, 3'b010);
    hold = 1'b0;
    wait_done("backpressure");
    bubbles = 1'b1;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < N; i++) repeat ($urandom_range(0, 2)) begin
        n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++) add(i, 8'($urandom), k == n - 1);
      end
      run_model();
      wait_done("random");
    end
    bubbles = 1'b0;
    add(2, 8'hA1, 0); add(2, 8'hA2, 0); add(2, 8'hA3, 1);
    run_model();
    n = 0;
    while (!tx_valid && n < 100) begin step(1); n++; end
    check("arst_reached_send", tx_valid, 1);
    rst_n = 1'b0;
    #1;
    check("arst_tx_valid", tx_valid, 0);
    check("arst_grant", grant, 0);
    check("arst_abort", abort, 0);
    flush();
    step(1);
    rst_n = 1'b1;
    model_rr = N - 1;
    for (int i = 0; i < N; i++) add(i, 8'($urandom), 1);
    run_model();
    wait_done("post_reset");
    check("post_reset_first", grant_log.size() > 0 ? grant_log[0] : -1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
